// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper ramp controller: FSM encoding,
// phase codes and saturating 32-bit arithmetic helpers.
package stepper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LAUNCH   = 3'd1,
        ST_ACCEL    = 3'd2,
        ST_CRUISE   = 3'd3,
        ST_DECEL    = 3'd4,
        ST_STOPPING = 3'd5,
        ST_FINISH   = 3'd6
    } state_t;

    localparam logic [1:0] PHASE_IDLE   = 2'd0;
    localparam logic [1:0] PHASE_ACCEL  = 2'd1;
    localparam logic [1:0] PHASE_CRUISE = 2'd2;
    localparam logic [1:0] PHASE_DECEL  = 2'd3;

    // a - b, clamped at zero instead of wrapping
    function automatic logic [31:0] sat_sub32(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

    // a + b, clamped at all-ones instead of wrapping
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    // Phase code reported for each state; launch, stopping and finish report idle
    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            ST_ACCEL:  return PHASE_ACCEL;
            ST_CRUISE: return PHASE_CRUISE;
            ST_DECEL:  return PHASE_DECEL;
            default:   return PHASE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/step_edge_detect.sv
// Flags a step boundary: any cycle where the micro-stepper's completed-step
// count differs from the value it had on the previous clock.
module step_edge_detect (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] count,
    output logic        boundary
);

    logic [31:0] count_q;

    // Keep last cycle's count for comparison
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count;
    end

    assign boundary = (count != count_q);

endmodule

// File: rtl/stepper_ramp_ctrl.sv
// Trapezoidal speed-ramp controller in front of a micro-stepper. Latches the
// move parameters, launches the move, walks the step period down to cruise
// and back up for the stop, and handles abort, emergency stop and go-timeout.
//
// Handshake with the micro-stepper: o_go is held high from launch until the
// controller stops; the move counts as accepted once i_motor_busy rises, and
// a later falling edge of i_motor_busy ends the move. i_step_count changes
// once per completed step; each change is a step boundary and the new period
// appears on o_period in the following cycle.
module stepper_ramp_ctrl
    import stepper_pkg::*;
#(
    parameter int GO_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_estop,
    input  logic [31:0] i_steps,
    input  logic        i_direction,
    input  logic [31:0] i_start_period,
    input  logic [31:0] i_min_period,
    input  logic [31:0] i_period_delta,
    input  logic        i_motor_busy,
    input  logic [31:0] i_step_count,
    output logic        o_go,
    output logic        o_stop,
    output logic [31:0] o_steps,
    output logic        o_direction,
    output logic [31:0] o_period,
    output logic [1:0]  o_phase,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_fault
);

    state_t      state;
    logic [31:0] start_lat;
    logic [31:0] min_lat;
    logic [31:0] delta_lat;
    logic [31:0] steps_tgt;
    logic [31:0] ramp_steps;
    logic [31:0] timer;
    logic        busy_q;
    logic        abort_pending;

    logic        boundary;
    logic        busy_fall;
    logic        decel_due;
    logic [31:0] steps_left;
    logic [31:0] period_dn_raw;
    logic [31:0] period_up_raw;
    logic [31:0] period_dn;
    logic [31:0] period_up;

    step_edge_detect u_edge (
        .clk      (clk),
        .rst      (rst),
        .count    (i_step_count),
        .boundary (boundary)
    );

    // Candidate periods for the next boundary and the decel trigger
    always_comb begin
        steps_left    = sat_sub32(steps_tgt, i_step_count);
        period_dn_raw = sat_sub32(o_period, delta_lat);
        period_up_raw = sat_add32(o_period, delta_lat);
        period_dn     = (period_dn_raw > min_lat) ? period_dn_raw : min_lat;
        period_up     = (period_up_raw < start_lat) ? period_up_raw : start_lat;
        busy_fall     = busy_q & ~i_motor_busy;
        decel_due     = (steps_left <= ramp_steps);
    end

    assign o_busy  = (state != ST_IDLE);
    assign o_phase = phase_of(state);

    // Move sequencer: state, latched parameters and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            start_lat     <= '0;
            min_lat       <= '0;
            delta_lat     <= '0;
            steps_tgt     <= '0;
            ramp_steps    <= '0;
            timer         <= '0;
            busy_q        <= 1'b0;
            abort_pending <= 1'b0;
            o_go          <= 1'b0;
            o_stop        <= 1'b0;
            o_steps       <= '0;
            o_direction   <= 1'b0;
            o_period      <= '0;
            o_done        <= 1'b0;
            o_fault       <= 1'b0;
        end else begin
            busy_q <= i_motor_busy;
            o_done <= 1'b0;
            o_stop <= 1'b0;
            if (i_estop && state != ST_IDLE && state != ST_FINISH) begin
                // Hard stop wins over everything, including a pending abort
                o_stop   <= 1'b1;
                o_go     <= 1'b0;
                o_done   <= 1'b1;
                o_period <= start_lat;
                state    <= ST_FINISH;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_start) begin
                            start_lat     <= i_start_period;
                            min_lat       <= i_min_period;
                            delta_lat     <= i_period_delta;
                            steps_tgt     <= i_steps;
                            o_steps       <= {i_steps[23:0], 8'h00};
                            o_direction   <= i_direction;
                            o_period      <= i_start_period;
                            ramp_steps    <= '0;
                            timer         <= '0;
                            abort_pending <= 1'b0;
                            o_fault       <= 1'b0;
                            if (i_steps == 32'd0) begin
                                o_done <= 1'b1;
                                state  <= ST_FINISH;
                            end else begin
                                o_go  <= 1'b1;
                                state <= ST_LAUNCH;
                            end
                        end
                    end
                    ST_LAUNCH: begin
                        if (i_motor_busy) begin
                            // No room to ramp: run the whole move at the start period
                            state <= (min_lat >= start_lat) ? ST_CRUISE : ST_ACCEL;
                        end else if (timer == 32'(GO_TIMEOUT - 1)) begin
                            o_fault  <= 1'b1;
                            o_go     <= 1'b0;
                            o_done   <= 1'b1;
                            o_period <= start_lat;
                            state    <= ST_FINISH;
                        end else begin
                            timer <= timer + 32'd1;
                        end
                    end
                    ST_ACCEL, ST_CRUISE: begin
                        if (busy_fall) begin
                            o_go     <= 1'b0;
                            o_done   <= 1'b1;
                            o_period <= start_lat;
                            state    <= ST_FINISH;
                        end else if (i_abort || decel_due) begin
                            // Abort shortens the move to exactly the ramp-down length
                            if (i_abort) begin
                                steps_tgt     <= i_step_count + ramp_steps;
                                abort_pending <= 1'b1;
                            end
                            if (boundary) o_period <= period_up;
                            state <= ST_DECEL;
                        end else if (state == ST_ACCEL) begin
                            if (o_period == min_lat) begin
                                state <= ST_CRUISE;
                            end else if (boundary) begin
                                o_period   <= period_dn;
                                ramp_steps <= ramp_steps + 32'd1;
                            end
                        end
                    end
                    ST_DECEL: begin
                        if (busy_fall) begin
                            o_go     <= 1'b0;
                            o_done   <= 1'b1;
                            o_period <= start_lat;
                            state    <= ST_FINISH;
                        end else if (abort_pending && o_period == start_lat) begin
                            o_go   <= 1'b0;
                            o_stop <= 1'b1;
                            state  <= ST_STOPPING;
                        end else if (boundary) begin
                            o_period <= period_up;
                        end
                    end
                    ST_STOPPING: begin
                        o_done   <= 1'b1;
                        o_period <= start_lat;
                        state    <= ST_FINISH;
                    end
                    ST_FINISH: begin
                        o_period <= start_lat;
                        if (!i_start) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stepper_ramp_ctrl.sv
// Directed bench for stepper_ramp_ctrl: trapezoid, triangle, abort, go-timeout,
// zero-length move, large delta with estop, no-ramp move and mid-move reset.
module tb_stepper_ramp_ctrl;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        i_abort;
    logic        i_estop;
    logic [31:0] i_steps;
    logic        i_direction;
    logic [31:0] i_start_period;
    logic [31:0] i_min_period;
    logic [31:0] i_period_delta;
    logic        i_motor_busy;
    logic [31:0] i_step_count;
    logic        o_go;
    logic        o_stop;
    logic [31:0] o_steps;
    logic        o_direction;
    logic [31:0] o_period;
    logic [1:0]  o_phase;
    logic        o_busy;
    logic        o_done;
    logic        o_fault;

    int pass_cnt  = 0;
    int total_cnt = 0;

    stepper_ramp_ctrl #(.GO_TIMEOUT(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_estop        (i_estop),
        .i_steps        (i_steps),
        .i_direction    (i_direction),
        .i_start_period (i_start_period),
        .i_min_period   (i_min_period),
        .i_period_delta (i_period_delta),
        .i_motor_busy   (i_motor_busy),
        .i_step_count   (i_step_count),
        .o_go           (o_go),
        .o_stop         (o_stop),
        .o_steps        (o_steps),
        .o_direction    (o_direction),
        .o_period       (o_period),
        .o_phase        (o_phase),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_fault        (o_fault)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; return 1 time unit after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Driver: present move parameters and pulse i_start for one cycle
    task automatic start_move(input logic [31:0] steps, input logic [31:0] sp,
                              input logic [31:0] mp, input logic [31:0] dp);
        i_steps        = steps;
        i_start_period = sp;
        i_min_period   = mp;
        i_period_delta = dp;
        i_start        = 1'b1;
        tick();
        i_start        = 1'b0;
    endtask

    // Driver: one step boundary, check the period a cycle later, then settle a cycle
    task automatic do_step(input int n, input logic [31:0] exp, input string tag);
        i_step_count = n;
        tick();
        chk(tag, o_period, exp);
        tick();
    endtask

    task automatic clear_count();
        i_step_count = 0;
        tick();
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_estop = 1'b0;
        i_steps = '0; i_direction = 1'b0; i_start_period = '0; i_min_period = '0;
        i_period_delta = '0; i_motor_busy = 1'b0; i_step_count = '0;
        ticks(2);
        chk("rst_go", o_go, 0);
        chk("rst_stop", o_stop, 0);
        chk("rst_period", o_period, 0);
        chk("rst_phase", o_phase, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_fault", o_fault, 0);
        rst = 1'b0;
        tick();

        // Full trapezoid: 100 steps, 1000 -> 200 in steps of 100
        i_direction = 1'b1;
        start_move(100, 1000, 200, 100);
        chk("trap_go", o_go, 1);
        chk("trap_steps", o_steps, 32'd25600);
        chk("trap_dir", o_direction, 1);
        chk("trap_period0", o_period, 1000);
        chk("trap_busy", o_busy, 1);
        i_motor_busy = 1'b1;
        tick();
        chk("trap_accel_phase", o_phase, 1);
        for (int k = 1; k <= 8; k++) do_step(k, 32'(1000 - 100 * k), $sformatf("trap_accel_%0d", k));
        chk("trap_cruise_phase", o_phase, 2);
        for (int k = 9; k <= 91; k++) begin
            i_step_count = k;
            tick();
        end
        chk("trap_cruise_period", o_period, 200);
        chk("trap_cruise_phase91", o_phase, 2);
        i_step_count = 92;
        tick();
        chk("trap_decel_phase", o_phase, 3);
        chk("trap_decel_92", o_period, 300);
        tick();
        for (int k = 93; k <= 99; k++) do_step(k, 32'(300 + 100 * (k - 92)), $sformatf("trap_decel_%0d", k));
        do_step(100, 1000, "trap_decel_100");
        i_motor_busy = 1'b0;
        tick();
        chk("trap_done", o_done, 1);
        chk("trap_go_off", o_go, 0);
        chk("trap_fin_period", o_period, 1000);
        tick();
        chk("trap_done_once", o_done, 0);
        chk("trap_idle", o_busy, 0);

        // Triangle: 6 steps, never reaches cruise
        clear_count();
        start_move(6, 1000, 200, 100);
        i_motor_busy = 1'b1;
        tick();
        do_step(1, 900, "tri_accel_1");
        chk("tri_phase_1", o_phase, 1);
        do_step(2, 800, "tri_accel_2");
        chk("tri_phase_2", o_phase, 1);
        do_step(3, 700, "tri_accel_3");
        chk("tri_phase_decel", o_phase, 3);
        do_step(4, 800, "tri_decel_4");
        do_step(5, 900, "tri_decel_5");
        do_step(6, 1000, "tri_decel_6");
        i_motor_busy = 1'b0;
        tick();
        chk("tri_done", o_done, 1);
        tick();

        // Abort while cruising at step 40
        clear_count();
        start_move(100, 1000, 200, 100);
        i_motor_busy = 1'b1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            i_step_count = k;
            tick();
        end
        chk("abort_cruise_phase", o_phase, 2);
        chk("abort_cruise_period", o_period, 200);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_decel_phase", o_phase, 3);
        for (int k = 41; k <= 48; k++) do_step(k, 32'(200 + 100 * (k - 40)), $sformatf("abort_decel_%0d", k));
        chk("abort_stop", o_stop, 1);
        chk("abort_go_off", o_go, 0);
        tick();
        chk("abort_stop_once", o_stop, 0);
        chk("abort_done", o_done, 1);
        tick();
        chk("abort_idle", o_busy, 0);
        i_motor_busy = 1'b0;

        // Motor never answers: fault after 16 launch cycles
        clear_count();
        start_move(10, 1000, 200, 100);
        chk("to_go", o_go, 1);
        ticks(15);
        chk("to_fault_early", o_fault, 0);
        chk("to_done_early", o_done, 0);
        tick();
        chk("to_fault", o_fault, 1);
        chk("to_done", o_done, 1);
        chk("to_go_off", o_go, 0);
        tick();
        chk("to_fault_sticky", o_fault, 1);
        chk("to_idle", o_busy, 0);

        // Zero-length move: done next cycle, fault cleared by the accepted start
        start_move(0, 1000, 200, 100);
        chk("zero_done", o_done, 1);
        chk("zero_go", o_go, 0);
        chk("zero_fault_clr", o_fault, 0);
        tick();
        chk("zero_idle", o_busy, 0);

        // Delta larger than start period, then estop together with abort
        start_move(20, 1000, 200, 2000);
        i_motor_busy = 1'b1;
        tick();
        do_step(1, 200, "bigdelta_sat");
        chk("bigdelta_cruise", o_phase, 2);
        i_estop = 1'b1;
        i_abort = 1'b1;
        tick();
        i_estop = 1'b0;
        i_abort = 1'b0;
        chk("estop_stop", o_stop, 1);
        chk("estop_done", o_done, 1);
        chk("estop_period", o_period, 1000);
        tick();
        chk("estop_stop_once", o_stop, 0);
        chk("estop_idle", o_busy, 0);
        i_motor_busy = 1'b0;

        // Minimum period not below start period: straight to cruise
        clear_count();
        start_move(10, 500, 600, 50);
        i_motor_busy = 1'b1;
        tick();
        chk("noramp_phase", o_phase, 2);
        chk("noramp_period", o_period, 500);
        i_motor_busy = 1'b0;
        tick();
        chk("noramp_done", o_done, 1);
        tick();

        // Reset in the middle of acceleration, then a clean restart
        clear_count();
        start_move(100, 1000, 200, 100);
        i_motor_busy = 1'b1;
        tick();
        do_step(1, 900, "rstmid_accel_1");
        do_step(2, 800, "rstmid_accel_2");
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_period", o_period, 0);
        chk("rstmid_go", o_go, 0);
        chk("rstmid_busy", o_busy, 0);
        chk("rstmid_steps", o_steps, 0);
        chk("rstmid_done", o_done, 0);
        tick();
        rst = 1'b0;
        i_motor_busy = 1'b0;
        i_step_count = 0;
        tick();
        chk("rstmid_no_done", o_done, 0);
        start_move(100, 1000, 200, 100);
        chk("restart_period", o_period, 1000);
        chk("restart_go", o_go, 1);
        i_motor_busy = 1'b1;
        tick();
        do_step(1, 900, "restart_accel_1");
        i_motor_busy = 1'b0;
        tick();
        chk("restart_done", o_done, 1);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
